// File: rtl/wb_stage.sv
// wb_stage: writeback pipeline stage with the integer register file.
// MEM/WB register (stall/flush), load formatting, writeback select, and a
// register file with two combinational read ports, write-through bypass and
// x0 hardwired to zero.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   stall, flush                  MEM/WB hold / bubble insert (flush wins)
//   in_*                          memory-stage results and control
//   rs1_addr/rs1_data, rs2_addr/rs2_data   register-file read ports
//   wb_valid, wb_we, wb_rd, wb_data        writeback status (for forwarding)
//   load_misaligned               WB load is misaligned; its write is suppressed
module wb_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  localparam int unsigned RW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic [XLEN-1:0] in_mem_data,
  input  logic [XLEN-1:0] in_pc4,
  input  logic [XLEN-1:0] in_imm,
  input  logic [2:0]      in_funct3,
  input  logic [RW-1:0]   in_rd,
  input  logic            in_reg_write,
  input  logic            in_mem_read,
  input  logic [1:0]      in_wb_sel,
  input  logic [RW-1:0]   rs1_addr,
  input  logic [RW-1:0]   rs2_addr,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [RW-1:0]   wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            load_misaligned
);

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] alu_out;
    logic [XLEN-1:0] mem_data;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] imm;
    logic [2:0]      funct3;
    logic [RW-1:0]   rd;
    logic            reg_write;
    logic            mem_read;
    logic [1:0]      wb_sel;
  } memwb_t;

  memwb_t          mw_q;
  logic [XLEN-1:0] regs [NREGS];
  logic [1:0]      off;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_val;
  logic            bad_f3;
  logic            misalign;

  // MEM/WB pipeline register; flush takes priority over stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mw_q <= '0;
    end else if (flush) begin
      mw_q <= '0;
    end else if (!stall) begin
      mw_q <= '{valid:     in_valid,
                alu_out:   in_alu_out,
                mem_data:  in_mem_data,
                pc4:       in_pc4,
                imm:       in_imm,
                funct3:    in_funct3,
                rd:        in_rd,
                reg_write: in_reg_write,
                mem_read:  in_mem_read,
                wb_sel:    in_wb_sel};
    end
  end

  // Load formatting: little-endian lane pick then sign/zero extension
  always_comb begin
    off      = mw_q.alu_out[1:0];
    byte_sel = mw_q.mem_data[8*off +: 8];
    half_sel = off[1] ? mw_q.mem_data[31:16] : mw_q.mem_data[15:0];
    load_val = '0;
    bad_f3   = 1'b0;
    misalign = 1'b0;
    case (mw_q.funct3)
      F3_LB:  load_val = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU: load_val = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH: begin
        load_val = {{(XLEN-16){half_sel[15]}}, half_sel};
        misalign = off[0];
      end
      F3_LHU: begin
        load_val = {{(XLEN-16){1'b0}}, half_sel};
        misalign = off[0];
      end
      F3_LW: begin
        load_val = mw_q.mem_data;
        misalign = (off != 2'b00);
      end
      default: bad_f3 = 1'b1;
    endcase
  end

  assign load_misaligned = mw_q.valid & mw_q.mem_read & (misalign | bad_f3);

  // Writeback value select
  always_comb begin
    wb_data = mw_q.alu_out;
    case (mw_q.wb_sel)
      2'b00:   wb_data = mw_q.alu_out;
      2'b01:   wb_data = load_val;
      2'b10:   wb_data = mw_q.pc4;
      default: wb_data = mw_q.imm;
    endcase
  end

  assign wb_valid = mw_q.valid;
  assign wb_rd    = mw_q.rd;
  // Not gated by stall: a held entry rewrites the same value, which is harmless
  assign wb_we    = mw_q.valid & mw_q.reg_write & (mw_q.rd != '0) & ~load_misaligned;

  // Register file; x0 is never written because wb_we excludes rd==0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else if (wb_we) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // Read ports with write-through bypass of the in-flight writeback
  always_comb begin
    if (wb_we && (rs1_addr == wb_rd)) rs1_data = wb_data;
    else if (rs1_addr == '0)          rs1_data = '0;
    else                              rs1_data = regs[rs1_addr];
    if (wb_we && (rs2_addr == wb_rd)) rs2_data = wb_data;
    else if (rs2_addr == '0)          rs2_data = '0;
    else                              rs2_data = regs[rs2_addr];
  end

endmodule
